// File: rtl/ctrl_pkg.sv
// Shared opcode/control-word constants, FSM state type and decode result type
// for the sequenced control unit.
package ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned SIG_W    = 23;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        IMM  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_NOT  = 7'b0010001;
    localparam logic [OPCODE_W-1:0] OP_INC  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_OUT  = 7'b0011001;
    localparam logic [OPCODE_W-1:0] OP_IN   = 7'b0011000;
    localparam logic [OPCODE_W-1:0] OP_HLT  = 7'b1100001;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 7'b1101000;
    localparam logic [OPCODE_W-1:0] OP_SETC = 7'b1100010;
    localparam logic [OPCODE_W-1:0] OP_MOV  = 7'b0010101;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 7'b0001101;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 7'b0001001;
    localparam logic [OPCODE_W-1:0] OP_AND  = 7'b0001111;
    localparam logic [OPCODE_W-1:0] OP_IADD = 7'b0100000;

    localparam logic [SIG_W-1:0] SIG_NOT  = 23'b01110111000101001100011;
    localparam logic [SIG_W-1:0] SIG_INC  = 23'b01110110000100001100011;
    localparam logic [SIG_W-1:0] SIG_OUT  = 23'b01100111000101011100011;
    localparam logic [SIG_W-1:0] SIG_IN   = 23'b01111111000101011100011;
    localparam logic [SIG_W-1:0] SIG_HLT  = 23'b00000011000001110000000;
    localparam logic [SIG_W-1:0] SIG_NOP  = 23'b01100111000001110100000;
    localparam logic [SIG_W-1:0] SIG_SETC = 23'b01100111000000011100010;
    localparam logic [SIG_W-1:0] SIG_MOV  = 23'b01110111000101011100011;
    localparam logic [SIG_W-1:0] SIG_ADD  = 23'b01110111000100001100011;
    localparam logic [SIG_W-1:0] SIG_SUB  = 23'b01110111000100101100011;
    localparam logic [SIG_W-1:0] SIG_AND  = 23'b01110111000100111100011;
    localparam logic [SIG_W-1:0] SIG_IADD = 23'b10110111100100001100011;

    typedef struct packed {
        logic [SIG_W-1:0] sig_word;
        logic             is_legal;
        logic             is_iadd;
        logic             is_hlt;
    } decode_t;

endpackage

// File: rtl/ctrl_decode_rom.sv
// Combinational opcode decoder; unknown opcodes map to the NOP word.
module ctrl_decode_rom
    import ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output decode_t             dec_c
);

    always_comb begin
        dec_c = '{sig_word: SIG_NOP, is_legal: 1'b1, is_iadd: 1'b0, is_hlt: 1'b0};
        case (opcode)
            OP_NOT:  dec_c.sig_word = SIG_NOT;
            OP_INC:  dec_c.sig_word = SIG_INC;
            OP_OUT:  dec_c.sig_word = SIG_OUT;
            OP_IN:   dec_c.sig_word = SIG_IN;
            OP_HLT: begin
                dec_c.sig_word = SIG_HLT;
                dec_c.is_hlt   = 1'b1;
            end
            OP_NOP:  dec_c.sig_word = SIG_NOP;
            OP_SETC: dec_c.sig_word = SIG_SETC;
            OP_MOV:  dec_c.sig_word = SIG_MOV;
            OP_ADD:  dec_c.sig_word = SIG_ADD;
            OP_SUB:  dec_c.sig_word = SIG_SUB;
            OP_AND:  dec_c.sig_word = SIG_AND;
            OP_IADD: begin
                dec_c.sig_word = SIG_IADD;
                dec_c.is_iadd  = 1'b1;
            end
            default: dec_c.is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_unit_seq.sv
// Sequenced control unit: valid/ready instruction intake, one-cycle registered
// control-word issue, IADD immediate sequencing, HALT, stall/flush, issue counter.
module ctrl_unit_seq #(
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned OPCODE_W = 7,
    parameter int unsigned SIG_W    = 23,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               stall,
    input  logic               flush,
    input  logic               resume,
    output logic [SIG_W-1:0]   signals,
    output logic               sig_valid,
    output logic [INSTR_W-1:0] imm_out,
    output logic               imm_valid,
    output logic               illegal,
    output logic               halted,
    output logic [CNT_W-1:0]   issue_cnt
);

    import ctrl_pkg::*;

    localparam int unsigned ROM_OPC_W = ctrl_pkg::OPCODE_W;

    state_e               state_q, state_d;
    logic [SIG_W-1:0]     signals_q, signals_d;
    logic                 sig_valid_q, sig_valid_d;
    logic [INSTR_W-1:0]   imm_q, imm_d;
    logic                 imm_valid_q, imm_valid_d;
    logic                 illegal_q, illegal_d;
    logic                 halted_q, halted_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [OPCODE_W-1:0]  opcode_c;
    decode_t              dec_c;
    logic                 accept_c;

    assign opcode_c    = instr[INSTR_W-1 -: OPCODE_W];
    assign instr_ready = !stall && (state_q == RUN || state_q == IMM);
    assign accept_c    = instr_valid && instr_ready;

    ctrl_decode_rom u_rom (
        .opcode (ROM_OPC_W'(opcode_c)),
        .dec_c  (dec_c)
    );

    // Flush beats stall beats normal operation; stall freezes every register.
    always_comb begin
        state_d     = state_q;
        signals_d   = signals_q;
        sig_valid_d = sig_valid_q;
        imm_d       = imm_q;
        imm_valid_d = imm_valid_q;
        illegal_d   = illegal_q;
        halted_d    = halted_q;
        cnt_d       = cnt_q;

        if (flush) begin
            sig_valid_d = 1'b0;
            imm_valid_d = 1'b0;
            illegal_d   = 1'b0;
            signals_d   = SIG_W'(SIG_NOP);
            if (state_q == IMM) begin
                state_d = RUN;
            end else if (state_q == HALT && resume && !stall) begin
                state_d  = RUN;
                halted_d = 1'b0;
            end
        end else if (!stall) begin
            sig_valid_d = 1'b0;
            imm_valid_d = 1'b0;
            illegal_d   = 1'b0;
            case (state_q)
                RUN: begin
                    if (accept_c) begin
                        if (dec_c.is_iadd) begin
                            state_d = IMM;
                        end else begin
                            signals_d   = SIG_W'(dec_c.sig_word);
                            sig_valid_d = 1'b1;
                            illegal_d   = !dec_c.is_legal;
                            cnt_d       = cnt_q + CNT_W'(1);
                            if (dec_c.is_hlt) begin
                                state_d  = HALT;
                                halted_d = 1'b1;
                            end
                        end
                    end
                end
                IMM: begin
                    // Second IADD word is raw immediate data, never decoded.
                    if (accept_c) begin
                        signals_d   = SIG_W'(SIG_IADD);
                        sig_valid_d = 1'b1;
                        imm_d       = instr;
                        imm_valid_d = 1'b1;
                        cnt_d       = cnt_q + CNT_W'(1);
                        state_d     = RUN;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state_d  = RUN;
                        halted_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = RUN;
                    halted_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            signals_q   <= '0;
            sig_valid_q <= 1'b0;
            imm_q       <= '0;
            imm_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            halted_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            signals_q   <= signals_d;
            sig_valid_q <= sig_valid_d;
            imm_q       <= imm_d;
            imm_valid_q <= imm_valid_d;
            illegal_q   <= illegal_d;
            halted_q    <= halted_d;
            cnt_q       <= cnt_d;
        end
    end

    assign signals   = signals_q;
    assign sig_valid = sig_valid_q;
    assign imm_out   = imm_q;
    assign imm_valid = imm_valid_q;
    assign illegal   = illegal_q;
    assign halted    = halted_q;
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_unit_seq.sv
// Bench for ctrl_unit_seq: directed vector table, async-reset sequences and
// randomized traffic against a behavioural model.
module tb_ctrl_unit_seq;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned SIG_W    = 23;
    localparam int unsigned CNT_W    = 4;
    localparam int          CNT_MOD  = 1 << CNT_W;

    localparam logic [6:0] OP_INC  = 7'b0000011;
    localparam logic [6:0] OP_HLT  = 7'b1100001;
    localparam logic [6:0] OP_NOP  = 7'b1101000;
    localparam logic [6:0] OP_ADD  = 7'b0001101;
    localparam logic [6:0] OP_SUB  = 7'b0001001;
    localparam logic [6:0] OP_AND  = 7'b0001111;
    localparam logic [6:0] OP_OUT  = 7'b0011001;
    localparam logic [6:0] OP_IADD = 7'b0100000;

    localparam logic [22:0] W_INC  = 23'b01110110000100001100011;
    localparam logic [22:0] W_HLT  = 23'b00000011000001110000000;
    localparam logic [22:0] W_NOP  = 23'b01100111000001110100000;
    localparam logic [22:0] W_ADD  = 23'b01110111000100001100011;
    localparam logic [22:0] W_SUB  = 23'b01110111000100101100011;
    localparam logic [22:0] W_AND  = 23'b01110111000100111100011;
    localparam logic [22:0] W_IADD = 23'b10110111100100001100011;

    localparam logic [6:0] OPS [12] = '{
        7'b0010001, 7'b0000011, 7'b0011001, 7'b0011000, 7'b1100001, 7'b1101000,
        7'b1100010, 7'b0010101, 7'b0001101, 7'b0001001, 7'b0001111, 7'b0100000};
    localparam logic [22:0] SIGS [12] = '{
        23'b01110111000101001100011, 23'b01110110000100001100011,
        23'b01100111000101011100011, 23'b01111111000101011100011,
        23'b00000011000001110000000, 23'b01100111000001110100000,
        23'b01100111000000011100010, 23'b01110111000101011100011,
        23'b01110111000100001100011, 23'b01110111000100101100011,
        23'b01110111000100111100011, 23'b10110111100100001100011};

    logic               clk = 1'b0;
    logic               reset;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid, instr_ready, stall, flush, resume;
    logic [SIG_W-1:0]   signals;
    logic               sig_valid, imm_valid, illegal, halted;
    logic [INSTR_W-1:0] imm_out;
    logic [CNT_W-1:0]   issue_cnt;

    always #5 clk = ~clk;

    ctrl_unit_seq #(
        .INSTR_W(INSTR_W), .OPCODE_W(OPCODE_W), .SIG_W(SIG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .stall(stall), .flush(flush), .resume(resume),
        .signals(signals), .sig_valid(sig_valid), .imm_out(imm_out),
        .imm_valid(imm_valid), .illegal(illegal), .halted(halted),
        .issue_cnt(issue_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: what has been issued, whether an immediate is owed, halted.
    logic [22:0] m_sig;
    logic        m_sv, m_iv, m_ill, m_halt, m_wait;
    logic [15:0] m_imm;
    int          m_cnt;

    task automatic model_reset();
        m_sig = '0; m_sv = 0; m_iv = 0; m_ill = 0; m_halt = 0; m_wait = 0;
        m_imm = '0; m_cnt = 0;
    endtask

    function automatic logic model_ready();
        return !stall && !m_halt;
    endfunction

    task automatic model_step();
        logic [6:0]  op;
        logic [22:0] w;
        logic        found;
        if (flush) begin
            m_sv = 0; m_iv = 0; m_ill = 0; m_sig = W_NOP; m_wait = 0;
            if (m_halt && resume && !stall) m_halt = 0;
        end else if (!stall) begin
            m_sv = 0; m_iv = 0; m_ill = 0;
            if (m_halt) begin
                if (resume) m_halt = 0;
            end else if (instr_valid) begin
                if (m_wait) begin
                    m_sig = W_IADD; m_sv = 1; m_imm = instr; m_iv = 1; m_wait = 0;
                    m_cnt = (m_cnt + 1) % CNT_MOD;
                end else begin
                    op = instr[15:9];
                    found = 0; w = W_NOP;
                    for (int k = 0; k < 12; k++)
                        if (OPS[k] == op) begin found = 1; w = SIGS[k]; end
                    if (found && op == OP_IADD) m_wait = 1;
                    else begin
                        m_sig = w; m_sv = 1; m_ill = !found;
                        m_cnt = (m_cnt + 1) % CNT_MOD;
                        if (found && op == OP_HLT) m_halt = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".signals"},   64'(signals),   64'(m_sig));
        check({tag, ".sig_valid"}, 64'(sig_valid), 64'(m_sv));
        check({tag, ".imm_out"},   64'(imm_out),   64'(m_imm));
        check({tag, ".imm_valid"}, 64'(imm_valid), 64'(m_iv));
        check({tag, ".illegal"},   64'(illegal),   64'(m_ill));
        check({tag, ".halted"},    64'(halted),    64'(m_halt));
        check({tag, ".issue_cnt"}, 64'(issue_cnt), 64'(m_cnt));
    endtask

    // Called at posedge+1; drives, checks ready, clocks once, checks outputs.
    task automatic apply(input logic [15:0] i, input logic v, input logic s,
                         input logic f, input logic r, input string tag,
                         output logic rdy_seen);
        instr = i; instr_valid = v; stall = s; flush = f; resume = r;
        #1;
        rdy_seen = instr_ready;
        check({tag, ".instr_ready"}, 64'(instr_ready), 64'(model_ready()));
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    function automatic logic [15:0] mk(input logic [6:0] op);
        return {op, 9'h000};
    endfunction

    typedef struct {
        logic [15:0] instr;
        logic        v, s, f, r, rdy;
        logic [22:0] sig;
        logic        sv, ill, halt, iv;
        logic [15:0] imm;
        logic [3:0]  cnt;
    } vec_t;

    function automatic vec_t vv(logic [15:0] i, logic v, logic s, logic f, logic r,
                                logic rdy, logic [22:0] sig, logic sv, logic ill,
                                logic halt, logic iv, logic [15:0] imm, logic [3:0] cnt);
        vec_t t;
        t.instr = i; t.v = v; t.s = s; t.f = f; t.r = r; t.rdy = rdy;
        t.sig = sig; t.sv = sv; t.ill = ill; t.halt = halt; t.iv = iv;
        t.imm = imm; t.cnt = cnt;
        return t;
    endfunction

    task automatic async_reset_check(input string tag);
        #3 reset = 1'b0;
        #1;
        check({tag, ".signals"},   64'(signals),   64'(0));
        check({tag, ".sig_valid"}, 64'(sig_valid), 64'(0));
        check({tag, ".imm_out"},   64'(imm_out),   64'(0));
        check({tag, ".imm_valid"}, 64'(imm_valid), 64'(0));
        check({tag, ".illegal"},   64'(illegal),   64'(0));
        check({tag, ".halted"},    64'(halted),    64'(0));
        check({tag, ".issue_cnt"}, 64'(issue_cnt), 64'(0));
        model_reset();
        instr_valid = 0; stall = 0; flush = 0; resume = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs[$];
        logic        rdy;
        logic [6:0]  op;
        string       tag;

        reset = 1'b0; instr = '0; instr_valid = 0; stall = 0; flush = 0; resume = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("por");
        check("por.instr_ready", 64'(instr_ready), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        vecs.push_back(vv(mk(OP_ADD),  1,0,0,0,1, W_ADD,  1,0,0,0, 16'h0000, 4'd1));
        vecs.push_back(vv(16'h0000,    0,0,0,0,1, W_ADD,  0,0,0,0, 16'h0000, 4'd1));
        vecs.push_back(vv(mk(OP_IADD), 1,0,0,0,1, W_ADD,  0,0,0,0, 16'h0000, 4'd1));
        vecs.push_back(vv(16'h00A5,    1,0,0,0,1, W_IADD, 1,0,0,1, 16'h00A5, 4'd2));
        vecs.push_back(vv(mk(7'h7F),   1,0,0,0,1, W_NOP,  1,1,0,0, 16'h00A5, 4'd3));
        vecs.push_back(vv(16'h0000,    0,0,0,0,1, W_NOP,  0,0,0,0, 16'h00A5, 4'd3));
        vecs.push_back(vv(mk(OP_HLT),  1,0,0,0,1, W_HLT,  1,0,1,0, 16'h00A5, 4'd4));
        for (int k = 0; k < 5; k++)
            vecs.push_back(vv(mk(OP_INC), 1,0,0,0,0, W_HLT, 0,0,1,0, 16'h00A5, 4'd4));
        vecs.push_back(vv(mk(OP_INC),  1,0,0,1,0, W_HLT,  0,0,0,0, 16'h00A5, 4'd4));
        vecs.push_back(vv(mk(OP_INC),  1,0,0,0,1, W_INC,  1,0,0,0, 16'h00A5, 4'd5));
        vecs.push_back(vv(mk(OP_IADD), 1,0,0,0,1, W_INC,  0,0,0,0, 16'h00A5, 4'd5));
        vecs.push_back(vv(16'h1234,    1,0,1,0,1, W_NOP,  0,0,0,0, 16'h00A5, 4'd5));
        vecs.push_back(vv(mk(OP_SUB),  1,0,0,0,1, W_SUB,  1,0,0,0, 16'h00A5, 4'd6));
        for (int k = 0; k < 3; k++)
            vecs.push_back(vv(mk(OP_AND), 1,1,0,0,0, W_SUB, 1,0,0,0, 16'h00A5, 4'd6));
        vecs.push_back(vv(mk(OP_AND),  1,0,0,0,1, W_AND,  1,0,0,0, 16'h00A5, 4'd7));
        vecs.push_back(vv(mk(OP_NOP),  1,0,0,1,1, W_NOP,  1,0,0,0, 16'h00A5, 4'd8));
        vecs.push_back(vv(mk(OP_OUT),  1,1,1,0,0, W_NOP,  0,0,0,0, 16'h00A5, 4'd8));

        foreach (vecs[n]) begin
            tag = $sformatf("vec%0d", n);
            apply(vecs[n].instr, vecs[n].v, vecs[n].s, vecs[n].f, vecs[n].r, tag, rdy);
            check({tag, ".t_ready"},   64'(rdy),       64'(vecs[n].rdy));
            check({tag, ".t_signals"}, 64'(signals),   64'(vecs[n].sig));
            check({tag, ".t_valid"},   64'(sig_valid), 64'(vecs[n].sv));
            check({tag, ".t_illegal"}, 64'(illegal),   64'(vecs[n].ill));
            check({tag, ".t_halted"},  64'(halted),    64'(vecs[n].halt));
            check({tag, ".t_imm_v"},   64'(imm_valid), 64'(vecs[n].iv));
            check({tag, ".t_imm"},     64'(imm_out),   64'(vecs[n].imm));
            check({tag, ".t_cnt"},     64'(issue_cnt), 64'(vecs[n].cnt));
        end

        // Stall while an immediate is owed, then asynchronous reset in IMM.
        apply(mk(OP_IADD), 1,0,0,0, "seqA.iadd", rdy);
        for (int k = 0; k < 3; k++) begin
            apply(16'h00FF, 1,1,0,0, "seqA.stall", rdy);
            check("seqA.stall_valid", 64'(sig_valid), 64'(0));
            check("seqA.stall_sig",   64'(signals),   64'(W_NOP));
        end
        async_reset_check("seqA.rst");
        apply(mk(OP_ADD) | 16'h00A5, 1,0,0,0, "seqA.after", rdy);
        check("seqA.after_sig", 64'(signals),   64'(W_ADD));
        check("seqA.after_imm", 64'(imm_valid), 64'(0));

        // Asynchronous reset while halted.
        apply(mk(OP_HLT), 1,0,0,0, "seqB.hlt", rdy);
        check("seqB.halted", 64'(halted), 64'(1));
        async_reset_check("seqB.rst");
        apply(mk(OP_SUB), 1,0,0,0, "seqB.after", rdy);
        check("seqB.after_sig", 64'(signals), 64'(W_SUB));

        // Randomized traffic; the narrow counter wraps many times.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) op = 7'($urandom_range(0, 127));
            else op = OPS[$urandom_range(0, 11)];
            apply({op, 9'($urandom_range(0, 511))},
                  1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 4) == 0),
                  "rnd", rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
